// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared constants and next-PC source encoding for pc_gen
package pc_gen_pkg;

    localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;
    localparam int          MISS_W       = 16;

    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_ERET,
        SRC_JR,
        SRC_J,
        SRC_BR,
        SRC_SEQ
    } npc_src_e;

endpackage

// File: rtl/pc_gen_ras.sv
// rtl/pc_gen_ras.sv - circular return-address stack with saturating misprediction counter
module pc_gen_ras
    import pc_gen_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [AW-1:0]     push_data,
    input  logic [AW-1:0]     pop_check,
    output logic [AW-1:0]     top,
    output logic              empty,
    output logic [MISS_W-1:0] miss
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]     r_stack [DEPTH];
    logic [PW-1:0]     r_ptr;
    logic [PW:0]       r_count;
    logic [MISS_W-1:0] r_miss;
    logic [PW-1:0]     w_top_idx;
    logic              w_mispredict;

    // r_ptr names the next free slot; on overflow it simply wraps onto the oldest entry
    assign w_top_idx    = r_ptr - PW'(1);
    assign empty        = (r_count == '0);
    assign top          = empty ? '0 : r_stack[w_top_idx];
    assign w_mispredict = empty || (r_stack[w_top_idx] != pop_check);
    assign miss         = r_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
            r_ptr   <= '0;
            r_count <= '0;
            r_miss  <= '0;
        end else if (push) begin
            r_stack[r_ptr] <= push_data;
            r_ptr          <= r_ptr + PW'(1);
            if (r_count != (PW+1)'(DEPTH)) begin
                r_count <= r_count + (PW+1)'(1);
            end
        end else if (pop) begin
            if (!empty) begin
                r_ptr   <= w_top_idx;
                r_count <= r_count - (PW+1)'(1);
            end
            if (w_mispredict && (r_miss != '1)) begin
                r_miss <= r_miss + MISS_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - registered PC generator with stall, exception/ERET redirect and
// an optional return-address stack enabled by PC_GEN_RAS_EN
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int          AW        = 32,
    parameter logic [AW-1:0] RESET_VEC = AW'(PC_RESET_VEC),
    parameter logic [AW-1:0] EXC_VEC   = AW'(PC_EXC_VEC),
    parameter int          RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_sel,
    input  logic              zero,
    input  logic              bltzal_sel,
    input  logic              sign,
    input  logic              j_sel,
    input  logic              jal_sel,
    input  logic              jr_sel,
    input  logic              jr_ra,
    input  logic [AW-1:0]     jr_val,
    input  logic [15:0]       imm,
    input  logic [25:0]       j26,
    input  logic              exc_req,
    input  logic              eret_sel,
    output logic [AW-1:0]     pc,
    output logic [AW-1:0]     pc4,
    output logic [AW-1:0]     npc,
    output logic [AW-1:0]     epc,
    output logic [AW-1:0]     ras_top,
    output logic [MISS_W-1:0] ras_miss
);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_epc;
    logic [AW-1:0] w_sext;
    logic [AW-1:0] w_br_tgt;
    logic [AW-1:0] w_j_tgt;
    logic          w_br_taken;
    logic          w_bltzal_taken;
    npc_src_e      w_src;

    assign pc             = r_pc;
    assign epc            = r_epc;
    assign pc4            = r_pc + AW'(4);
    assign w_sext         = {{(AW-16){imm[15]}}, imm};
    // Offset is relative to the branch itself, not the delay-slot PC
    assign w_br_tgt       = r_pc + (w_sext << 2);
    assign w_j_tgt        = {r_pc[AW-1:28], j26, 2'b00};
    assign w_bltzal_taken = bltzal_sel & sign;
    assign w_br_taken     = (br_sel & zero) | w_bltzal_taken;

    always_comb begin
        w_src = SRC_SEQ;
        if (exc_req)                w_src = SRC_EXC;
        else if (eret_sel)          w_src = SRC_ERET;
        else if (jr_sel)            w_src = SRC_JR;
        else if (j_sel || jal_sel)  w_src = SRC_J;
        else if (w_br_taken)        w_src = SRC_BR;
    end

    always_comb begin
        npc = pc4;
        case (w_src)
            SRC_EXC:  npc = EXC_VEC;
            SRC_ERET: npc = r_epc;
            SRC_JR:   npc = jr_val;
            SRC_J:    npc = w_j_tgt;
            SRC_BR:   npc = w_br_tgt;
            default:  npc = pc4;
        endcase
    end

    // Exception entry overrides stall so a stalled pipeline can still trap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= RESET_VEC;
            r_epc <= '0;
        end else if (exc_req) begin
            r_epc <= r_pc;
            r_pc  <= EXC_VEC;
        end else if (!stall) begin
            r_pc <= npc;
        end
    end

`ifdef PC_GEN_RAS_EN
    logic w_push;
    logic w_pop;
    logic w_ras_empty;

    assign w_push = !stall && (((w_src == SRC_J) && jal_sel) ||
                               ((w_src == SRC_BR) && w_bltzal_taken));
    assign w_pop  = !stall && (w_src == SRC_JR) && jr_ra;

    pc_gen_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (pc4),
        .pop_check (jr_val),
        .top       (ras_top),
        .empty     (w_ras_empty),
        .miss      (ras_miss)
    );
`else
    logic w_unused;

    assign w_unused = jr_ra | (RAS_DEPTH == 0);
    assign ras_top  = '0;
    assign ras_miss = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - table-driven directed checks for pc_gen, RAS checks follow PC_GEN_RAS_EN
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_sel, zero, bltzal_sel, sign, j_sel, jal_sel, jr_sel, jr_ra;
    logic        exc_req, eret_sel;
    logic [31:0] jr_val;
    logic [15:0] imm;
    logic [25:0] j26;
    logic [31:0] pc, pc4, npc, epc, ras_top;
    logic [15:0] ras_miss;

    int checks = 0;
    int errors = 0;

    pc_gen dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_sel(br_sel), .zero(zero),
        .bltzal_sel(bltzal_sel), .sign(sign), .j_sel(j_sel), .jal_sel(jal_sel),
        .jr_sel(jr_sel), .jr_ra(jr_ra), .jr_val(jr_val), .imm(imm), .j26(j26),
        .exc_req(exc_req), .eret_sel(eret_sel), .pc(pc), .pc4(pc4), .npc(npc),
        .epc(epc), .ras_top(ras_top), .ras_miss(ras_miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, br, zero, bltzal, sign, j, jal, jr, jr_ra, exc, eret;
        logic [31:0] jr_val;
        logic [15:0] imm;
        logic [25:0] j26;
        logic [31:0] exp_npc, exp_pc, exp_epc;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic st, br, z, bl, sg, j, jal, jr, ra, exc, eret,
                                input logic [31:0] jv, input logic [15:0] im,
                                input logic [25:0] jj, input logic [31:0] en, ep, ee);
        vec_t v;
        v.stall = st; v.br = br; v.zero = z; v.bltzal = bl; v.sign = sg; v.j = j;
        v.jal = jal; v.jr = jr; v.jr_ra = ra; v.exc = exc; v.eret = eret;
        v.jr_val = jv; v.imm = im; v.j26 = jj;
        v.exp_npc = en; v.exp_pc = ep; v.exp_epc = ee;
        return v;
    endfunction

    function automatic logic [31:0] ras(input logic [31:0] x);
        return RAS_EN ? x : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall = 0; br_sel = 0; zero = 0; bltzal_sel = 0; sign = 0; j_sel = 0;
        jal_sel = 0; jr_sel = 0; jr_ra = 0; exc_req = 0; eret_sel = 0;
        jr_val = '0; imm = '0; j26 = '0;
    endtask

    task automatic apply(input vec_t v);
        stall = v.stall; br_sel = v.br; zero = v.zero; bltzal_sel = v.bltzal;
        sign = v.sign; j_sel = v.j; jal_sel = v.jal; jr_sel = v.jr; jr_ra = v.jr_ra;
        exc_req = v.exc; eret_sel = v.eret; jr_val = v.jr_val; imm = v.imm; j26 = v.j26;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            st br z bl sg j jal jr ra ex er jr_val        imm       j26        npc           pc            epc
        vecs[0]  = mk(0, 0,0,0, 0, 0,0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     32'h3004,     32'h3004,     32'h0);
        vecs[1]  = mk(0, 0,0,0, 0, 0,0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     32'h3008,     32'h3008,     32'h0);
        vecs[2]  = mk(1, 1,0,0, 0, 0,0, 0, 0, 0, 0, 32'h0,       16'hFFFF, 26'h0,     32'h300C,     32'h3008,     32'h0);
        vecs[3]  = mk(0, 1,1,0, 0, 0,0, 0, 0, 0, 0, 32'h0,       16'hFFFF, 26'h0,     32'h3004,     32'h3004,     32'h0);
        vecs[4]  = mk(0, 0,0,1, 0, 0,0, 0, 0, 0, 0, 32'h0,       16'h0003, 26'h0,     32'h3008,     32'h3008,     32'h0);
        vecs[5]  = mk(0, 1,1,0, 0, 0,0, 0, 0, 0, 0, 32'h0,       16'h0002, 26'h0,     32'h3010,     32'h3010,     32'h0);
        vecs[6]  = mk(0, 0,0,0, 0, 0,1, 0, 0, 0, 0, 32'h0,       16'h0,    26'hC10,   32'h3040,     32'h3040,     32'h0);
        vecs[7]  = mk(0, 0,0,0, 0, 0,0, 1, 1, 0, 0, 32'h3014,    16'h0,    26'h0,     32'h3014,     32'h3014,     32'h0);
        vecs[8]  = mk(0, 0,0,0, 0, 1,0, 0, 0, 0, 0, 32'h0,       16'h0,    26'hC08,   32'h3020,     32'h3020,     32'h0);
        vecs[9]  = mk(1, 0,0,0, 0, 0,0, 0, 0, 1, 0, 32'h0,       16'h0,    26'h0,     32'h4180,     32'h4180,     32'h3020);
        vecs[10] = mk(0, 0,0,0, 0, 0,0, 0, 0, 0, 1, 32'h0,       16'h0,    26'h0,     32'h3020,     32'h3020,     32'h3020);
        vecs[11] = mk(1, 1,1,0, 0, 1,0, 1, 0, 0, 0, 32'h5000,    16'h0,    26'h0,     32'h5000,     32'h3020,     32'h3020);
        vecs[12] = mk(1, 1,1,0, 0, 1,0, 1, 0, 1, 0, 32'h5000,    16'h0,    26'h0,     32'h4180,     32'h4180,     32'h3020);
        vecs[13] = mk(0, 0,0,0, 0, 0,0, 0, 0, 0, 1, 32'h0,       16'h0,    26'h0,     32'h3020,     32'h3020,     32'h3020);
        vecs[14] = mk(0, 0,0,0, 0, 0,0, 1, 0, 0, 0, 32'hFFFFFFFC,16'h0,    26'h0,     32'hFFFFFFFC, 32'hFFFFFFFC, 32'h3020);
        vecs[15] = mk(0, 0,0,0, 0, 0,0, 0, 0, 0, 0, 32'h0,       16'h0,    26'h0,     32'h0,        32'h0,        32'h3020);
        vecs[16] = mk(0, 1,1,0, 0, 0,0, 0, 0, 0, 0, 32'h0,       16'hFFFF, 26'h0,     32'hFFFFFFFC, 32'hFFFFFFFC, 32'h3020);

        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", pc, 32'h3000);
        chk("reset_pc4", pc4, 32'h3004);
        chk("reset_epc", epc, 32'h0);
        chk("reset_ras_top", ras_top, 32'h0);
        chk("reset_ras_miss", {16'h0, ras_miss}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("vec%0d_npc", i), npc, vecs[i].exp_npc);
            tick();
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_pc4", i), pc4, vecs[i].exp_pc + 32'd4);
            chk($sformatf("vec%0d_epc", i), epc, vecs[i].exp_epc);
            if (i == 6) chk("jal_ras_top", ras_top, ras(32'h3014));
            if (i == 7) begin
                chk("jr_ras_top", ras_top, 32'h0);
                chk("jr_ras_miss", {16'h0, ras_miss}, 32'h0);
            end
            idle();
        end

        // mid-run reset with a pending jump: async clear, then the jump is discarded
        j_sel = 1; j26 = 26'h123;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_pc", pc, 32'h3000);
        chk("midreset_epc", epc, 32'h0);
        chk("midreset_miss", {16'h0, ras_miss}, 32'h0);
        tick();
        chk("midreset_hold_pc", pc, 32'h3000);
        idle();
        rst_n = 1'b1;
        tick();
        chk("after_reset_pc", pc, 32'h3004);

        jr_sel = 1; jr_val = 32'h3000;
        tick();
        idle();
        chk("rewind_pc", pc, 32'h3000);

        // five JALs into a four-entry stack
        for (int k = 0; k < 5; k++) begin
            jal_sel = 1;
            j26 = 26'((32'h3100 + 32'(k) * 32'h100) >> 2);
            tick();
            idle();
            chk($sformatf("ovf_jal%0d_pc", k), pc, 32'h3100 + 32'(k) * 32'h100);
            chk($sformatf("ovf_jal%0d_top", k), ras_top, ras(32'h3004 + 32'(k) * 32'h100));
        end
        for (int k = 0; k < 5; k++) begin
            jr_sel = 1; jr_ra = 1;
            jr_val = 32'h3404 - 32'(k) * 32'h100;
            tick();
            idle();
            chk($sformatf("ovf_jr%0d_pc", k), pc, 32'h3404 - 32'(k) * 32'h100);
            chk($sformatf("ovf_jr%0d_miss", k), {16'h0, ras_miss}, ras((k < 4) ? 32'h0 : 32'h1));
        end
        chk("ovf_empty_top", ras_top, 32'h0);

        // taken BLTZAL pushes the link value; stalled JAL must not push
        bltzal_sel = 1; sign = 1; imm = 16'h0004;
        #1;
        chk("bltzal_npc", npc, 32'h3014);
        tick();
        idle();
        chk("bltzal_pc", pc, 32'h3014);
        chk("bltzal_top", ras_top, ras(32'h3008));
        stall = 1; jal_sel = 1; j26 = 26'hC40;
        tick();
        idle();
        chk("stall_jal_pc", pc, 32'h3014);
        chk("stall_jal_top", ras_top, ras(32'h3008));
        jr_sel = 1; jr_ra = 1; jr_val = 32'h1234;
        tick();
        idle();
        chk("jr_wrong_pc", pc, 32'h1234);
        chk("jr_wrong_miss", {16'h0, ras_miss}, ras(32'h2));
        chk("jr_wrong_top", ras_top, 32'h0);
        jr_sel = 1; jr_ra = 1; jr_val = 32'h1238;
        tick();
        idle();
        chk("jr_empty_miss", {16'h0, ras_miss}, ras(32'h3));
        chk("jr_empty_top", ras_top, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Registered program-counter generator for the single-cycle/multicycle MIPS datapath. It replaces the purely combinational next-PC selector with a PC register, and generalises it in address width, reset and exception vectors, and return-address stack depth. It adds stall and exception/ERET redirection, plus an optional return-address stack (RAS) with a misprediction counter. It sits between instruction fetch (drives `pc`) and the decode/ALU stage (supplies select lines, `zero`, `sign`, `jr_val`).

## Interface
- `AW`, 32: PC/address width, ≥ 28+2.
- `RESET_VEC`, `32'h0000_3000`: PC after reset.
- `EXC_VEC`, `32'h0000_4180`: PC on exception entry.
- `RAS_DEPTH`, 4: RAS entries, power of two, ≥ 2.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC (ignored for `exc_req`).
- `br_sel`  in  1  BEQ-type branch, taken when `zero`.
- `zero`  in  1  ALU zero flag.
- `bltzal_sel`  in  1  BLTZAL, taken when `sign`.
- `sign`  in  1  rs[31] from the register file.
- `j_sel`  in  1  J.
- `jal_sel`  in  1  JAL.
- `jr_sel`  in  1  JR.
- `jr_ra`  in  1  JR source register is $31.
- `jr_val`  in  AW  JR target.
- `imm`  in  16  branch offset.
- `j26`  in  26  jump index.
- `exc_req`  in  1  exception request.
- `eret_sel`  in  1  return from exception.
- `pc`  out  AW  current PC (register).
- `pc4`  out  AW  `pc + 4`, link value.
- `npc`  out  AW  next PC (combinational).
- `epc`  out  AW  saved exception PC (register).
- `ras_top`  out  AW  RAS prediction for a pending `$ra` return.
- `ras_miss`  out  16  saturating RAS misprediction count.

## Operation
- Branch target: `pc + (sext(imm) << 2)`, modulo 2^AW. There is no +4 term.
- Jump target: `{pc[AW-1:28], j26, 2'b00}`.
- `npc` priority, highest first:
  - `exc_req` → `EXC_VEC`
  - `eret_sel` → `epc`
  - `jr_sel` → `jr_val`
  - `j_sel | jal_sel` → jump target
  - `(br_sel & zero) | (bltzal_sel & sign)` → branch target
  - otherwise → `pc4`
- Several selects may be asserted at once. Only the highest-priority select takes effect.
- Exception entry: `epc <= pc` and `pc <= EXC_VEC`, even when `stall` is high.
- When `stall` is high and `exc_req` is low, `pc`, `epc` and the RAS all hold. No push or pop occurs.
- RAS push: `jal_sel` or a taken BLTZAL, when it is the winning select, pushes `pc4`.
  - On a full stack, the push overwrites the oldest entry (circular). The count saturates at `RAS_DEPTH`.
- RAS pop: a winning `jr_sel` with `jr_ra` pops.
  - If the stack is empty, or the popped value ≠ `jr_val`, `ras_miss` increments, saturating at `16'hFFFF`.
  - Pop on an empty stack leaves the count at 0.
- `ras_top` shows the top entry, or 0 when the stack is empty.
- ERET and exceptions do not touch the RAS.

## Timing
- `pc`, `epc`, RAS and `ras_miss` update at the rising edge of `clk`.
- `npc`, `pc4` and `ras_top` are combinational, with zero latency from inputs.
- A redirect is visible on `pc` one cycle after the select is sampled.
- Reset values, applied asynchronously when `rst_n` falls: `pc = RESET_VEC`, `epc = 0`, RAS count 0 with all entries 0, `ras_miss = 0`.
  - Therefore `pc4 = RESET_VEC+4` and `ras_top = 0`.
- Reset asserted mid-operation discards any pending redirect. The first edge after `rst_n` rises advances from `RESET_VEC`.
- PC wrap-around: `pc4` of `{AW{1'b1}} - 3` is 0. There is no trap.

## Configuration
- With `PC_GEN_RAS_EN` defined: the RAS and miss counter exist as described.
- Without it: no RAS storage. `ras_top` and `ras_miss` are tied to 0, and `jr_ra` is ignored.
  - PC and EPC behaviour is identical in both builds.

## Structure
- Shared package `pc_gen_pkg` holds:
  - the default `RESET_VEC` and `EXC_VEC` constants;
  - the next-PC source enum (`SRC_EXC`, `SRC_ERET`, `SRC_JR`, `SRC_J`, `SRC_BR`, `SRC_SEQ`);
  - the miss-counter width constant.
- One sub-module, `pc_gen_ras`: circular stack with `push`, `pop`, `push_data`, `top`, `empty` and the miss counter.
  - It is instantiated only under `PC_GEN_RAS_EN`.

## Test plan
- Reset: assert `rst_n=0` mid-run → `pc=0x3000`, `epc=0`, `ras_miss=0`. After release, one idle edge → `pc=0x3004`.
- Branch: at `pc=0x3008`, `br_sel=1`, `zero=1`, `imm=0xFFFF` → `npc=0x3004`. With `zero=0` → `npc=0x300C`.
- JAL/JR:
  - At `pc=0x3010`, `jal_sel=1`, `j26=0x0000C10` → `pc=0x3040` and `ras_top=0x3014`.
  - Then `jr_sel=1`, `jr_ra=1`, `jr_val=0x3014` → `pc=0x3014`, `ras_miss=0`, stack empty.
- Exception under stall: at `pc=0x3020`, `stall=1`, `exc_req=1` → `pc=0x4180`, `epc=0x3020`. Then `eret_sel=1` → `pc=0x3020`.
- RAS overflow (`RAS_DEPTH=4`):
  - Five JALs from `pc` = `0x3000`, `0x3100`, `0x3200`, `0x3300`, `0x3400`.
  - Then five `$ra` JRs with `jr_val` = `0x3404`, `0x3304`, `0x3204`, `0x3104`, `0x3004` → `ras_miss=1`.
  - The last pop finds the stack empty.
- Priority: `jr_sel=1`, `j_sel=1`, `br_sel=1`, `zero=1`, `jr_val=0x5000` → `npc=0x5000`. Adding `exc_req=1` → `npc=0x4180`.
